// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the CPU-to-APB bridge: window offsets, CTRL/STATUS
// bit positions, FSM state encoding and byte-lane helpers.
package apb_bridge_pkg;

  // Register window offsets
  localparam logic [3:0] OffWdata0 = 4'd0;
  localparam logic [3:0] OffAddr0  = 4'd4;
  localparam logic [3:0] OffCtrl   = 4'd8;
  localparam logic [3:0] OffStatus = 4'd9;
  localparam logic [3:0] OffRdata0 = 4'd12;

  // CTRL bit positions (write-only)
  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlWriteBit = 1;
  localparam int unsigned CtrlSlaveLsb = 2;
  localparam int unsigned CtrlSlaveMsb = 4;

  // STATUS bit positions (read-only)
  localparam int unsigned StatusBusyBit    = 0;
  localparam int unsigned StatusDoneBit    = 1;
  localparam int unsigned StatusTimeoutBit = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

  // Little-endian byte lane extract
  function automatic logic [7:0] get_byte(logic [31:0] word, logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

  // Little-endian byte lane replace
  function automatic logic [31:0] set_byte(logic [31:0] word, logic [1:0] idx, logic [7:0] val);
    logic [31:0] res;
    res = word;
    res[{idx, 3'b000} +: 8] = val;
    return res;
  endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase wait counter. Cleared by load_i, advances while en_i is high,
// and flags expired_o during the Cycles-th enabled cycle.
module apb_timeout_counter #(
  parameter int unsigned Cycles = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Cycles - 1);

  logic [CntW-1:0] cnt_q;

  assign expired_o = en_i && (cnt_q == LastCnt);

  // Count elapsed ACCESS cycles; stop at the last one since the FSM leaves then.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_apb_master_bridge.sv
// Byte-wide CPU register window driving single 32-bit APB transfers.
// Optional macro APB_BRIDGE_TIMEOUT_EN adds the ACCESS-phase timeout counter
// and STATUS.timeout; without it ACCESS waits for pready indefinitely.
module cpu_apb_master_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cpu_sel,
  input  logic                  cpu_we_n,
  input  logic [3:0]            cpu_addr,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  irq_n,
  output logic [NUM_SLAVES-1:0] psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [31:0]           paddr,
  output logic [31:0]           pwdata,
  input  logic                  pready,
  input  logic [31:0]           prdata
);

  apb_state_e            state_q;
  logic [31:0]           wdata_q, addr_q, rdata_q;
  logic [31:0]           paddr_q, pwdata_q;
  logic [NUM_SLAVES-1:0] psel_q;
  logic                  penable_q, pwrite_q;
  logic                  done_q, timeout_q;

  logic                  busy;
  logic                  cpu_wr;
  logic                  ctrl_wr;
  logic [2:0]            ctrl_slave;
  logic [NUM_SLAVES-1:0] sel_onehot;
  logic [7:0]            status;
  logic                  expired;

  assign busy       = (state_q != StIdle);
  assign cpu_wr     = cpu_sel && !cpu_we_n;
  assign ctrl_wr    = cpu_wr && !busy && (cpu_addr == OffCtrl);
  assign ctrl_slave = cpu_din[CtrlSlaveMsb:CtrlSlaveLsb];

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign irq_n   = ~done_q;

`ifdef APB_BRIDGE_TIMEOUT_EN
  logic acc_load, acc_run;

  assign acc_load = (state_q == StSetup);
  assign acc_run  = (state_q == StAccess);

  apb_timeout_counter #(
    .Cycles (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (pclk),
    .rst_ni    (presetn),
    .load_i    (acc_load),
    .en_i      (acc_run),
    .expired_o (expired)
  );
`else
  logic unused_timeout_cfg;

  assign expired            = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Decode the CTRL slave index; indices beyond NUM_SLAVES select nothing.
  always_comb begin
    sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if ({29'd0, ctrl_slave} == i) sel_onehot[i] = 1'b1;
    end
  end

  // Assemble the STATUS byte.
  always_comb begin
    status                   = 8'h00;
    status[StatusBusyBit]    = busy;
    status[StatusDoneBit]    = done_q;
    status[StatusTimeoutBit] = timeout_q;
  end

  // CPU readback mux; CTRL and unmapped offsets read as zero.
  always_comb begin
    cpu_dout = 8'h00;
    case (cpu_addr[3:2])
      OffWdata0[3:2]: cpu_dout = get_byte(wdata_q, cpu_addr[1:0]);
      OffAddr0[3:2]:  cpu_dout = get_byte(addr_q, cpu_addr[1:0]);
      OffCtrl[3:2]:   if (cpu_addr == OffStatus) cpu_dout = status;
      OffRdata0[3:2]: cpu_dout = get_byte(rdata_q, cpu_addr[1:0]);
      default:        cpu_dout = 8'h00;
    endcase
  end

  // Staged WDATA/ADDR byte writes, frozen while a transfer is in flight.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wdata_q <= '0;
      addr_q  <= '0;
    end else if (cpu_wr && !busy) begin
      if (cpu_addr[3:2] == OffWdata0[3:2]) begin
        wdata_q <= set_byte(wdata_q, cpu_addr[1:0], cpu_din);
      end else if (cpu_addr[3:2] == OffAddr0[3:2]) begin
        addr_q <= set_byte(addr_q, cpu_addr[1:0], cpu_din);
      end
    end
  end

  // Transfer FSM with registered APB outputs and status flags.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= StIdle;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ctrl_wr) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            if (cpu_din[CtrlStartBit]) begin
              psel_q   <= sel_onehot;
              pwrite_q <= cpu_din[CtrlWriteBit];
              paddr_q  <= addr_q;
              pwdata_q <= wdata_q;
              state_q  <= StSetup;
            end
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          state_q   <= StAccess;
        end
        StAccess: begin
          // With no slave selected nobody can answer, so only the timeout ends it.
          if (pready && (|psel_q)) begin
            if (!pwrite_q) rdata_q <= prdata;
            psel_q    <= '0;
            penable_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StIdle;
          end else if (expired) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_apb_master_bridge.sv
// Self-checking bench for cpu_apb_master_bridge: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model.
module tb_cpu_apb_master_bridge;

  localparam int unsigned NSLV = 6;
  localparam int unsigned TCYC = 4;
`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic            pclk = 1'b0;
  logic            presetn = 1'b0;
  logic            cpu_sel = 1'b0;
  logic            cpu_we_n = 1'b1;
  logic [3:0]      cpu_addr = 4'd0;
  logic [7:0]      cpu_din = 8'd0;
  logic [7:0]      cpu_dout;
  logic            irq_n;
  logic [NSLV-1:0] psel;
  logic            penable, pwrite;
  logic [31:0]     paddr, pwdata;
  logic            pready = 1'b0;
  logic [31:0]     prdata = 32'd0;

  always #5 pclk = ~pclk;

  cpu_apb_master_bridge #(
    .NUM_SLAVES     (NSLV),
    .TIMEOUT_CYCLES (TCYC)
  ) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .cpu_sel  (cpu_sel),
    .cpu_we_n (cpu_we_n),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .irq_n    (irq_n),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .prdata   (prdata)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] m_wdata = 0, m_addr = 0, m_rdata = 0, m_xa = 0, m_xd = 0;
  bit          m_wr = 0, m_done = 0, m_to = 0, m_xfer = 0;
  int unsigned m_slv = 0, m_n = 0;  // m_n: edges since the START edge

  function automatic logic [NSLV-1:0] onehot(input int unsigned s);
    logic [NSLV-1:0] r;
    r = '0;
    if (s < NSLV) r[s] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] exp_dout(input logic [3:0] a);
    int unsigned ai;
    logic [31:0] t;
    ai = a;
    t = 32'd0;
    if (ai < 4) t = m_wdata >> (8 * ai);
    else if (ai < 8) t = m_addr >> (8 * (ai - 4));
    else if (ai == 9) t = {29'd0, m_to, m_done, m_xfer};
    else if (ai >= 12) t = m_rdata >> (8 * (ai - 12));
    return t[7:0];
  endfunction

  always @(negedge presetn) begin
    m_wdata = 0; m_addr = 0; m_rdata = 0; m_xa = 0; m_xd = 0;
    m_wr = 0; m_done = 0; m_to = 0; m_xfer = 0; m_slv = 0; m_n = 0;
  end

  always @(posedge pclk) begin
    if (presetn) begin : model_step
      bit was_busy;
      int unsigned a;
      was_busy = m_xfer;
      if (m_xfer) begin
        m_n++;
        if (m_n >= 2) begin
          if (pready === 1'b1 && m_slv < NSLV) begin
            if (!m_wr) m_rdata = prdata;
            m_xfer = 0;
            m_done = 1;
          end else if (ToEn && (m_n - 1) >= TCYC) begin
            m_xfer = 0;
            m_done = 1;
            m_to = 1;
          end
        end
      end
      if (cpu_sel && !cpu_we_n && !was_busy) begin
        a = cpu_addr;
        if (a < 4) m_wdata[8*a +: 8] = cpu_din;
        else if (a < 8) m_addr[8*(a-4) +: 8] = cpu_din;
        else if (a == 8) begin
          m_done = 0;
          m_to = 0;
          if (cpu_din[0]) begin
            m_xfer = 1; m_n = 0; m_wr = cpu_din[1]; m_slv = cpu_din[4:2];
            m_xa = m_addr; m_xd = m_wdata;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge pclk) begin
    if (cmp_en) begin
      chk("psel", 32'(psel), 32'(m_xfer ? onehot(m_slv) : '0));
      chk("penable", 32'(penable), 32'(m_xfer && m_n >= 1));
      chk("pwrite", 32'(pwrite), 32'(m_wr));
      chk("paddr", paddr, m_xa);
      chk("pwdata", pwdata, m_xd);
      chk("irq_n", 32'(irq_n), 32'(!m_done));
      chk("cpu_dout", 32'(cpu_dout), 32'(exp_dout(cpu_addr)));
    end
  end

  // ---------------- APB responder ----------------
  int          ws = 0, ws_cur = 0, acc = 0;
  bit          rand_ws = 0, noise = 0;
  logic [31:0] resp_data = 32'h0;

  always @(posedge pclk) begin
    #1;
    if (penable) acc++; else acc = 0;
    if (acc == 1) begin
      ws_cur = rand_ws ? int'($urandom_range(0, 6)) : ws;
      if (rand_ws) resp_data = $urandom;
    end
    if (penable && (|psel)) pready = (acc > ws_cur);
    else pready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    prdata = pready ? resp_data : $urandom;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge pclk);
    #2;
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    cpu_sel = 1; cpu_we_n = 0; cpu_addr = a; cpu_din = d;
    tick();
    cpu_sel = 0; cpu_we_n = 1;
  endtask

  task automatic cpu_rd(input logic [3:0] a, input logic [7:0] exp, input string name);
    cpu_sel = 1; cpu_we_n = 1; cpu_addr = a;
    #1;
    chk(name, 32'(cpu_dout), 32'(exp));
    tick();
    cpu_sel = 0;
  endtask

  task automatic rand_op();
    logic [7:0] d;
    cpu_addr = 4'($urandom_range(0, 15));
    cpu_sel  = ($urandom_range(0, 3) != 0);
    cpu_we_n = 1'($urandom_range(0, 1));
    d = 8'($urandom);
    if (!ToEn && cpu_addr == 4'd8) d[4:2] = 3'($urandom_range(0, NSLV - 1));
    cpu_din = d;
    tick();
    cpu_sel = 0; cpu_we_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc_cnt, setups, bound;
    logic [7:0] d;

    // Reset state
    repeat (3) tick();
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_pwrite", 32'(pwrite), 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_irq_n", 32'(irq_n), 1);
    presetn = 1;
    cmp_en = 1;
    cpu_rd(4'd9, 8'h00, "rst_status");
    cpu_rd(4'd12, 8'h00, "rst_rdata0");

    // Write transfer, pready immediately
    ws = 0;
    cpu_wr(4'd4, 8'h10); cpu_wr(4'd5, 8'h00); cpu_wr(4'd6, 8'h00); cpu_wr(4'd7, 8'h00);
    cpu_wr(4'd0, 8'hEF); cpu_wr(4'd1, 8'hBE); cpu_wr(4'd2, 8'hAD); cpu_wr(4'd3, 8'hDE);
    cpu_wr(4'd8, 8'h07);
    chk("wr_setup_psel", 32'(psel), 32'h02);
    chk("wr_setup_penable", 32'(penable), 0);
    chk("wr_setup_pwdata", pwdata, 32'hDEADBEEF);
    chk("wr_setup_paddr", paddr, 32'h10);
    chk("wr_setup_pwrite", 32'(pwrite), 1);
    tick();
    chk("wr_access_psel", 32'(psel), 32'h02);
    chk("wr_access_penable", 32'(penable), 1);
    chk("wr_access_irq_n", 32'(irq_n), 1);
    tick();
    chk("wr_done_psel", 32'(psel), 0);
    chk("wr_done_irq_n", 32'(irq_n), 0);
    cpu_rd(4'd9, 8'h02, "wr_status_done");

    // Read transfer with 4 wait states
    ws = 4;
    resp_data = 32'h12345678;
    cpu_wr(4'd8, 8'h05);
    chk("rd_setup_pwrite", 32'(pwrite), 0);
    acc_cnt = 0;
    for (int i = 0; i < 20 && psel != '0; i++) begin
      tick();
      if (penable) begin
        acc_cnt++;
        chk("rd_paddr_stable", paddr, 32'h10);
      end
    end
    chk("rd_access_cycles", 32'(acc_cnt), 5);
    cpu_rd(4'd12, 8'h78, "rd_rdata0");
    cpu_rd(4'd13, 8'h56, "rd_rdata1");
    cpu_rd(4'd14, 8'h34, "rd_rdata2");
    cpu_rd(4'd15, 8'h12, "rd_rdata3");

    // Busy lockout during a stalled write
    ws = 6;
    cpu_wr(4'd8, 8'h07);
    cpu_wr(4'd0, 8'hFF);
    cpu_wr(4'd8, 8'h01);
    chk("lock_pwdata", pwdata, 32'hDEADBEEF);
    setups = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (psel != '0 && !penable) setups++;
    end
    chk("lock_no_second_xfer", 32'(setups), 0);
    cpu_rd(4'd0, 8'hEF, "lock_wdata_byte0");
    cpu_rd(4'd9, 8'h02, "lock_status");

`ifdef APB_BRIDGE_TIMEOUT_EN
    // Timeout after TCYC ACCESS cycles
    ws = 1000;
    cpu_wr(4'd8, 8'h05);
    repeat (TCYC) tick();
    chk("to_last_access_psel", 32'(psel), 32'h02);
    chk("to_last_access_penable", 32'(penable), 1);
    tick();
    chk("to_psel_dropped", 32'(psel), 0);
    chk("to_penable_dropped", 32'(penable), 0);
    cpu_rd(4'd9, 8'h06, "to_status");
    cpu_rd(4'd12, 8'h78, "to_rdata_kept");
    cpu_wr(4'd8, 8'h00);
    cpu_rd(4'd9, 8'h00, "to_status_cleared");
    chk("to_irq_n_cleared", 32'(irq_n), 1);
    // Out-of-range slave index: nothing selected, ends by timeout
    cpu_wr(4'd8, 8'h19);
    chk("bad_slave_psel", 32'(psel), 0);
    repeat (TCYC + 1) tick();
    cpu_rd(4'd9, 8'h06, "bad_slave_status");
    cpu_wr(4'd8, 8'h00);
`else
    // Without the timeout feature a stall simply persists
    ws = 8;
    cpu_wr(4'd8, 8'h05);
    repeat (6) tick();
    cpu_rd(4'd9, 8'h01, "stall_busy");
    bound = 0;
    while (m_xfer && bound < 30) begin tick(); bound++; end
    chk("stall_bound", 32'(m_xfer), 0);
    cpu_rd(4'd9, 8'h02, "stall_done");
`endif

    // Asynchronous reset mid-ACCESS
    ws = 1000;
    cpu_wr(4'd8, 8'h07);
    tick();
    tick();
    cpu_sel = 1; cpu_we_n = 1; cpu_addr = 4'd9;
    presetn = 0;
    #1;
    chk("arst_psel", 32'(psel), 0);
    chk("arst_penable", 32'(penable), 0);
    chk("arst_irq_n", 32'(irq_n), 1);
    chk("arst_status", 32'(cpu_dout), 0);
    chk("arst_pwdata", pwdata, 0);
    tick();
    presetn = 1;
    cpu_sel = 0;
    ws = 0;
    tick();

    // Unmapped offsets
    cpu_wr(4'd0, 8'h5A);
    cpu_wr(4'd10, 8'hA5);
    cpu_wr(4'd11, 8'h3C);
    cpu_rd(4'd10, 8'h00, "unmapped_10");
    cpu_rd(4'd11, 8'h00, "unmapped_11");
    cpu_rd(4'd0, 8'h5A, "unmapped_wdata_kept");
    cpu_rd(4'd4, 8'h00, "unmapped_addr_kept");
    cpu_rd(4'd9, 8'h00, "unmapped_status");
    cpu_rd(4'd8, 8'h00, "ctrl_reads_zero");

    // Randomized traffic against the model
    rand_ws = 1;
    noise = 1;
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) rand_op();
      d = 8'($urandom);
      d[0] = 1'b1;
      if (!ToEn) d[4:2] = 3'($urandom_range(0, NSLV - 1));
      cpu_wr(4'd8, d);
      bound = 0;
      while (m_xfer && bound < 60) begin rand_op(); bound++; end
      chk("rand_idle_bound", 32'(m_xfer), 0);
    end
    noise = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_apb_master_bridge.md
Name: cpu_apb_master_bridge

Overview:
- APB initiator on the CPU clock domain (pclk = clk_div4).
- Turns 8-bit m6502-style byte accesses into single 32-bit APB transfers toward the amba_apb_bus master port.
- The CPU stages the address, the write data and the slave select through a 16-byte register window, then starts the transfer and polls status.
- On reads, prdata is captured for byte readback.

Parameters:
- NUM_SLAVES, 8, width of the one-hot psel vector.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles waiting for pready before abort; minimum 1.

Ports:
- pclk  in  1  bridge and APB clock.
- presetn  in  1  asynchronous active-low reset.
- cpu_sel  in  1  CPU access targets this window.
- cpu_we_n  in  1  0=write, 1=read.
- cpu_addr  in  4  byte offset in window.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data; combinational mux of registers.
- irq_n  out  1  active-low, asserted while done=1.
- psel  out  NUM_SLAVES  one-hot APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  32  APB address.
- pwdata  out  32  APB write data.
- pready  in  1  responder ready.
- prdata  in  32  responder read data.

Behaviour:
- Window offsets:
  - 0-3 WDATA bytes, little-endian.
  - 4-7 ADDR bytes.
  - 8 CTRL (W): bit0 START, bit1 WRITE, bits4:2 SLAVE index.
  - 9 STATUS (R): bit0 busy, bit1 done, bit2 timeout.
  - 12-15 RDATA bytes (R).
  - Other offsets read 0; writes to them are ignored.
- Reset: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0. WDATA/ADDR/RDATA=0, status=0, irq_n=1, FSM=IDLE.
- A CPU write to a byte register takes effect at the pclk edge while cpu_sel=1 and cpu_we_n=0.
- Writes to WDATA, ADDR or CTRL while busy=1 are ignored.
- IDLE:
  - CTRL write with START=1 and busy=0: clear done and timeout, set busy, go to SETUP next cycle.
  - CTRL write with START=0: clears done and timeout only.
- SETUP (1 cycle):
  - psel[SLAVE]=1, penable=0; paddr, pwdata and pwrite driven from the staged registers.
  - Next state is ACCESS.
- ACCESS:
  - penable=1; psel, paddr, pwdata and pwrite held stable.
  - If pready=1: transfer completes. If pwrite=0, prdata is latched into RDATA on that edge. Then psel=0, penable=0, busy=0, done=1, go to IDLE.
  - A slave index of NUM_SLAVES or more selects nothing (psel=0). The transfer completes only via timeout.
- Minimum latency: START edge to done=1 is 3 pclk cycles, with pready=1 on the first ACCESS cycle.
- Timeout:
  - ACCESS cycle counter resets on entry to ACCESS.
  - When TIMEOUT_CYCLES cycles elapse without pready: drop psel/penable, set timeout=1 and done=1, leave RDATA unchanged, go to IDLE.
- pready sampled outside ACCESS is ignored.
- A CPU read of STATUS in the same cycle that done sets returns the pre-edge value.
- presetn asserted mid-transfer: everything returns to reset values immediately (asynchronously). No transfer is completed.
- irq_n = ~done.

Optional Feature:
- APB_BRIDGE_TIMEOUT_EN.
- Defined: timeout counter and STATUS bit2 are present as described.
- Undefined: no counter; ACCESS waits indefinitely for pready; STATUS bit2 reads 0; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package/header apb_bridge_pkg holds:
  - register offset constants;
  - CTRL/STATUS bit positions;
  - FSM state encodings IDLE/SETUP/ACCESS.
- One sub-module is natural: apb_timeout_counter (load, enable, expired output), instantiated only under APB_BRIDGE_TIMEOUT_EN.

Test Plan:
- Write: stage ADDR=0x0000_0010, WDATA=0xDEADBEEF, CTRL=0x07 (slave 1, write, start); responder pready=1 immediately.
  - Required: psel=0x02 for 2 cycles, penable only in the second, pwdata=0xDEADBEEF.
  - done=1 and irq_n=0 three cycles after START.
- Read with wait states: CTRL=0x05 (slave 1, read); responder holds pready=0 for 4 ACCESS cycles, then returns prdata=0x12345678.
  - Required: RDATA bytes 12-15 read 0x78, 0x56, 0x34, 0x12; paddr stable throughout ACCESS.
- Busy lockout: during a stalled transfer, write WDATA byte0=0xFF and CTRL=0x01.
  - Required: both ignored; pwdata unchanged; a single transfer only.
- Timeout (macro on, TIMEOUT_CYCLES=4): pready held 0.
  - Required: after 4 ACCESS cycles psel=0; STATUS=0x06; RDATA unchanged.
  - Writing CTRL=0x00 clears STATUS to 0x00 and sets irq_n=1.
- Reset mid-ACCESS: drop presetn.
  - Required: psel=0, penable=0, STATUS=0, irq_n=1 without waiting for a pclk edge.
- Unmapped offset 10: reads 0x00; a write changes no register.
